mmio_io_port: RTL and testbench

Memory-mapped I/O responder on the data-memory side of the `risc_v` single-cycle core. The core's loads and stores drive the bus, and this block answers them. An input FIFO, filled by an external producer, feeds the core's `lw`. An output FIFO, drained by an external consumer, captures the core's `sw`. A status word and a last-written `CPUOut` register complete the port. It replaces the hard-wired `CPUIn`/`CPUOut` pins with a buffered, handshaked interface.

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/mmio_io_port_fifo.sv | 68 ++++++
 rtl/mmio_io_port.sv | 147 ++++++++++++++
 tb/tb_mmio_io_port.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped I/O port:
// default register addresses, status-word bit positions and the status layout.
package mmio_pkg;

    // Default word addresses decoded on the core's data bus.
    localparam logic [31:0] IN_ADDR   = 32'hFFFF_FFFC;
    localparam logic [31:0] OUT_ADDR  = 32'hFFFF_FFF8;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF_FFF4;

    // Bit positions inside the status word.
    localparam int ST_IN_NEMPTY   = 0;
    localparam int ST_OUT_FULL    = 1;
    localparam int ST_OUT_OVF     = 2;
    localparam int ST_IN_UDF      = 3;
    localparam int ST_IN_CNT_LSB  = 4;
    localparam int ST_OUT_CNT_LSB = 8;
    localparam int STATUS_W       = 12;

    // Status word as seen by software, LSB last.
    typedef struct packed {
        logic [3:0] out_count;
        logic [3:0] in_count;
        logic       in_underflow;
        logic       out_overflow;
        logic       out_full;
        logic       in_not_empty;
    } mmio_status_t;

endpackage

// File: rtl/mmio_io_port_fifo.sv
// Small synchronous FIFO with a fall-through head. Push is ignored when full
// and pop is ignored when empty, so callers may drive raw request strobes.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic             do_push, do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is forced to zero while empty so stale storage never leaks out.
    assign rdata = empty ? '0 : mem[rd_ptr_reg];

    // Pointer and occupancy update; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_next = do_push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next = do_pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Control state registers; reset discards all buffered entries.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_io_port.sv
// Memory-mapped I/O responder for the single-cycle core's data bus: an input
// FIFO feeding lw, an output FIFO capturing sw, a status word and CPUOut.
module mmio_io_port #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] IN_ADDR   = mmio_pkg::IN_ADDR,
    parameter logic [31:0] OUT_ADDR  = mmio_pkg::OUT_ADDR,
    parameter logic [31:0] STAT_ADDR = mmio_pkg::STAT_ADDR
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWData,
    input  logic        MemWE,
    input  logic        MemRE,
    output logic [31:0] MemRData,
    output logic        Hit,
    input  logic [31:0] InData,
    input  logic        InValid,
    output logic        InReady,
    output logic [31:0] OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] CPUOut
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int N_ADDR = 3;
    localparam logic [N_ADDR*32-1:0] ADDR_TABLE = {STAT_ADDR, OUT_ADDR, IN_ADDR};

    logic [N_ADDR-1:0] addr_match;
    logic              sel_in, sel_out, sel_stat;
    logic              rd_act, in_pop_req, out_push_req, out_push, stat_rd;
    logic              udf_set, ovf_set;
    logic              udf_reg, udf_next, ovf_reg, ovf_next;
    logic [31:0]       cpu_out_reg, cpu_out_next;
    logic [31:0]       in_head;
    logic              in_full, in_empty, out_full, out_empty;
    logic [CW-1:0]     in_count, out_count;
    mmio_pkg::mmio_status_t status;

    // Exact 32-bit compare against each register address.
    genvar gi;
    generate
        for (gi = 0; gi < N_ADDR; gi++) begin : g_decode
            assign addr_match[gi] = (MemAddr == ADDR_TABLE[gi*32 +: 32]);
        end
    endgenerate

    assign sel_in   = addr_match[0];
    assign sel_out  = addr_match[1];
    assign sel_stat = addr_match[2];
    assign Hit      = |addr_match;

    // A store takes priority; a load is only acted on without a store.
    assign rd_act       = MemRE && !MemWE;
    assign in_pop_req   = rd_act && sel_in;
    assign stat_rd      = rd_act && sel_stat;
    assign out_push_req = MemWE && sel_out;
    assign out_push     = out_push_req && !out_full;
    assign udf_set      = in_pop_req && in_empty;
    assign ovf_set      = out_push_req && out_full;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (CLK),
        .srst  (Reset),
        .push  (InValid),
        .pop   (in_pop_req),
        .wdata (InData),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    // Full is sampled at cycle start, so a same-cycle consumer pop cannot
    // make room for a store.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (CLK),
        .srst  (Reset),
        .push  (out_push),
        .pop   (OutReady),
        .wdata (MemWData),
        .rdata (OutData),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    assign InReady  = !in_full;
    assign OutValid = !out_empty;
    assign CPUOut   = cpu_out_reg;

    // Sticky error bits: set has priority over the clear-on-status-read.
    always_comb begin
        udf_next     = udf_reg;
        ovf_next     = ovf_reg;
        cpu_out_next = cpu_out_reg;
        if (udf_set) begin
            udf_next = 1'b1;
        end else if (stat_rd) begin
            udf_next = 1'b0;
        end
        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (stat_rd) begin
            ovf_next = 1'b0;
        end
        if (out_push) begin
            cpu_out_next = MemWData;
        end
    end

    // Sticky bits and last-stored word.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            udf_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            cpu_out_reg <= '0;
        end else begin
            udf_reg     <= udf_next;
            ovf_reg     <= ovf_next;
            cpu_out_reg <= cpu_out_next;
        end
    end

    // Assemble the status word from live FIFO state and the sticky bits.
    always_comb begin
        status              = '0;
        status.in_not_empty = !in_empty;
        status.out_full     = out_full;
        status.out_overflow = ovf_reg;
        status.in_underflow = udf_reg;
        status.in_count     = 4'(in_count);
        status.out_count    = 4'(out_count);
    end

    // Zero-latency read mux; empty input FIFO already presents zero.
    always_comb begin
        MemRData = '0;
        if (rd_act && sel_in) begin
            MemRData = in_head;
        end else if (rd_act && sel_stat) begin
            MemRData = {{(32 - mmio_pkg::STATUS_W){1'b0}}, status};
        end
    end

endmodule

// File: tb/tb_mmio_io_port.sv
// Directed scoreboard bench for mmio_io_port (DEPTH = 4).
module tb_mmio_io_port;

    localparam logic [31:0] A_IN   = 32'hFFFF_FFFC;
    localparam logic [31:0] A_OUT  = 32'hFFFF_FFF8;
    localparam logic [31:0] A_STAT = 32'hFFFF_FFF4;
    localparam int          D      = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] MemAddr, MemWData, MemRData, InData, OutData, CPUOut;
    logic        MemWE, MemRE, Hit, InValid, InReady, OutValid, OutReady;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboards: expected contents of each FIFO, plus expected CPUOut.
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic [31:0] cpuout_m = '0;

    mmio_io_port #(.DEPTH(D)) dut (
        .CLK(CLK), .Reset(Reset), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemWE(MemWE), .MemRE(MemRE), .MemRData(MemRData), .Hit(Hit),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .CPUOut(CPUOut)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat(input int ni, input int no, input bit ovf, input bit udf);
        logic [31:0] r;
        r        = '0;
        r[0]     = (ni != 0);
        r[1]     = (no == D);
        r[2]     = ovf;
        r[3]     = udf;
        r[7:4]   = ni[3:0];
        r[11:8]  = no[3:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic status_read(input string tag, input logic [31:0] exp);
        MemAddr = A_STAT; MemRE = 1'b1;
        #1;
        $display("[TB] lw STAT -> %h", MemRData);
        chk(tag, MemRData, exp);
        tick();
        MemRE = 1'b0;
    endtask

    task automatic ext_push(input logic [31:0] v);
        InData = v; InValid = 1'b1;
        if (in_q.size() < D) in_q.push_back(v);
        $display("[TB] ext push %h", v);
        tick();
        InValid = 1'b0;
    endtask

    task automatic lw_in(input logic [31:0] push_v, input bit with_push);
        logic [31:0] exp;
        bit          was_full;
        was_full = (in_q.size() >= D);
        exp = (in_q.size() > 0) ? in_q.pop_front() : 32'h0;
        MemAddr = A_IN; MemRE = 1'b1;
        InData = push_v; InValid = with_push;
        #1;
        $display("[TB] lw IN -> %h (push %0d)", MemRData, with_push);
        chk("lw_in_data", MemRData, exp);
        chk("lw_in_hit", {31'b0, Hit}, 32'd1);
        tick();
        MemRE = 1'b0; InValid = 1'b0;
        if (with_push && !was_full) in_q.push_back(push_v);
    endtask

    task automatic sw_out(input logic [31:0] v);
        MemAddr = A_OUT; MemWData = v; MemWE = 1'b1;
        #1;
        chk("sw_out_hit", {31'b0, Hit}, 32'd1);
        $display("[TB] sw OUT %h", v);
        tick();
        MemWE = 1'b0;
        if (out_q.size() < D) begin
            out_q.push_back(v);
            cpuout_m = v;
        end
        chk("cpuout", CPUOut, cpuout_m);
    endtask

    task automatic drain_one();
        logic [31:0] exp;
        exp = out_q.pop_front();
        chk("outvalid_drain", {31'b0, OutValid}, 32'd1);
        chk("outdata", OutData, exp);
        $display("[TB] consumer pop %h", OutData);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; MemAddr = '0; MemWData = '0; MemWE = 1'b0; MemRE = 1'b0;
        InData = '0; InValid = 1'b0; OutReady = 1'b0;

        // Reset state
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_cpuout",   CPUOut, 32'h0);
        chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst_inready",  {31'b0, InReady}, 32'd1);
        chk("rst_outdata",  OutData, 32'h0);
        status_read("rst_status", exp_stat(0, 0, 0, 0));

        // Input path with underflow and sticky clear
        ext_push(32'd8);
        ext_push(32'd50);
        status_read("in_status2", exp_stat(2, 0, 0, 0));
        lw_in(32'h0, 1'b0);
        lw_in(32'h0, 1'b0);
        lw_in(32'h0, 1'b0);
        status_read("udf_status", exp_stat(0, 0, 0, 1));
        status_read("udf_cleared", exp_stat(0, 0, 0, 0));

        // Output path
        sw_out(32'd42);
        chk("outvalid_one", {31'b0, OutValid}, 32'd1);
        status_read("out_status1", exp_stat(0, 1, 0, 0));
        drain_one();
        chk("outvalid_drop", {31'b0, OutValid}, 32'd0);

        // Output overflow
        for (int i = 1; i <= 4; i++) sw_out(i);
        status_read("out_full", exp_stat(0, 4, 0, 0));
        sw_out(32'd5);
        chk("ovf_cpuout", CPUOut, 32'd4);
        status_read("ovf_status", exp_stat(0, 4, 1, 0));
        status_read("ovf_cleared", exp_stat(0, 4, 0, 0));
        for (int i = 0; i < 4; i++) drain_one();
        chk("drained_valid", {31'b0, OutValid}, 32'd0);
        chk("drained_data", OutData, 32'h0);

        // Input full and concurrent traffic
        for (int i = 11; i <= 14; i++) ext_push(i);
        chk("in_full_ready", {31'b0, InReady}, 32'd0);
        status_read("in_full_status", exp_stat(4, 0, 0, 0));
        lw_in(32'd15, 1'b1);
        chk("in_ready_back", {31'b0, InReady}, 32'd1);
        status_read("after_full_pop", exp_stat(3, 0, 0, 0));
        lw_in(32'd16, 1'b1);
        status_read("concurrent_cnt", exp_stat(3, 0, 0, 0));
        ext_push(32'd17);
        status_read("refilled", exp_stat(4, 0, 0, 0));

        // Non-matching address, both strobes, reset mid-operation
        sw_out(32'd77);
        MemAddr = 32'hFFFF_FFFA; MemWData = 32'd99; MemWE = 1'b1;
        #1;
        chk("nomatch_hit", {31'b0, Hit}, 32'd0);
        $display("[TB] sw FFFFFFFA %h", MemWData);
        tick();
        MemWE = 1'b0;
        chk("nomatch_cpuout", CPUOut, 32'd77);
        status_read("nomatch_status", exp_stat(4, 1, 0, 0));
        MemAddr = A_IN; MemRE = 1'b1; MemWE = 1'b1; MemWData = 32'd123;
        #1;
        chk("both_rdata", MemRData, 32'h0);
        $display("[TB] lw+sw IN -> %h", MemRData);
        tick();
        MemRE = 1'b0; MemWE = 1'b0;
        status_read("both_status", exp_stat(4, 1, 0, 0));

        Reset = 1'b1;
        $display("[TB] reset mid-operation");
        tick();
        Reset = 1'b0;
        in_q.delete(); out_q.delete(); cpuout_m = '0;
        chk("mid_rst_cpuout",   CPUOut, 32'h0);
        chk("mid_rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("mid_rst_inready",  {31'b0, InReady}, 32'd1);
        status_read("mid_rst_status", exp_stat(0, 0, 0, 0));
        lw_in(32'h0, 1'b0);
        status_read("mid_rst_udf", exp_stat(0, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
